rlwe_vec_lsu: RTL
=================

Name: rlwe_vec_lsu

Overview:
Multi-beat vector load/store unit for the RLWE core. It accepts one whole-vector command from EXU (LANES elements of ELEM_W bits). It issues the command to DMEM as a sequence of narrower beats: unit-stride uses BEAT_LANES elements per beat, strided uses one element per beat. Load beats are gathered into a vector buffer, and the unit returns a single completion or exception to EXU. It supersedes the single-beat LSU path for LV/SV and adds strided access.

Parameters:
LANES, 16, elements per vector (power of two)
ELEM_W, 32, element width in bits (fixed 32 for word addressing)
BEAT_LANES, 4, elements per unit-stride DMEM beat (power of two, divides LANES)
AW, 32, address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
exu2lsu_req  in  1  command valid; held until lsu2exu_rdy
exu2lsu_cmd  in  3  0 NONE, 1 LV, 2 SV, 3 LVS (strided load), 4 SVS (strided store)
exu2lsu_addr  in  AW  vector base byte address
exu2lsu_stride  in  AW  byte stride for LVS/SVS (signed)
exu2lsu_s_data  in  LANES*ELEM_W  store vector, lane 0 in LSBs
lsu2exu_rdy  out  1  one-cycle completion pulse
lsu2exu_l_data  out  LANES*ELEM_W  gathered load vector
lsu2exu_exc  out  1  exception, valid with rdy
lsu2exu_exc_code  out  4  4 ld-misalign, 5 ld-access, 6 st-misalign, 7 st-access
lsu_busy  out  1  command in progress
lsu2dmem_req  out  1  beat request
lsu2dmem_cmd  out  1  0 RD, 1 WR
lsu2dmem_width  out  2  0 BYTE, 1 HWORD, 2 WORD, 3 BEAT
lsu2dmem_addr  out  AW  beat byte address
lsu2dmem_wdata  out  BEAT_LANES*ELEM_W  beat store data
dmem2lsu_req_ack  in  1  beat accepted this cycle
dmem2lsu_rdata  in  BEAT_LANES*ELEM_W  beat read data
dmem2lsu_resp  in  2  0 IDLE, 1 OK, 2 ER

Behaviour:
- Reset (rst_n low at posedge, any state): state IDLE; beat counter 0; load buffer 0.
  - All outputs read 0 after reset: rdy, exc, exc_code, busy, dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata, l_data.
  - Reset mid-command abandons the command; any later DMEM response is ignored while IDLE.
- Beat count NB: LV/SV = LANES/BEAT_LANES; LVS/SVS = LANES.
- Alignment is checked in IDLE, combinationally on the request:
  - LV/SV: addr mod (BEAT_LANES*4) must be 0.
  - LVS/SVS: addr[1:0] and stride[1:0] must be 0.
  - On violation: rdy=1, exc=1, code 4 (loads) or 6 (stores) in the same cycle. No DMEM request is issued, state stays IDLE.
  - cmd NONE with req: rdy=1, exc=0 in the same cycle.
- IDLE -> REQ on a legal req. Capture cmd, base, stride and s_data into registers; beat index k=0.
- REQ: dmem_req=1.
  - addr = base + k*BEAT_LANES*4 (unit) or base + k*stride (strided, modulo 2^AW).
  - width = BEAT (unit) or WORD (strided).
  - wdata = store lanes [k*BEAT_LANES +: BEAT_LANES] (unit), or lane k in beat lane 0 with other lanes 0 (strided).
  - Hold all of these until req_ack, then go to WAIT.
- WAIT: dmem_req=0. Responses are accepted only in WAIT.
  - OK, load: write beat data into buffer lanes (unit: all BEAT_LANES; strided: beat lane 0 -> lane k).
  - OK and k<NB-1: k++, go to REQ.
  - OK and k=NB-1: go to DONE.
  - ER: go to DONE with the error flag set; remaining beats are never issued. Buffer lanes already written keep their values; the rest keep their prior contents.
- DONE: rdy=1 for one cycle, l_data = buffer (registered, stable until the next load writes it). exc = error flag, code 5 (load) or 7 (store). Next cycle goes to IDLE.
- busy=1 in REQ, WAIT and DONE.
- Only one beat is outstanding at a time. Minimum latency with zero-wait DMEM (ack in the REQ cycle, resp the next cycle): 2*NB+1 cycles from accept to rdy.
- EXU must drop req, or present a new command, the cycle after rdy. A req seen in DONE is ignored.

Decomposition:
- Shared package rlwe_vlsu_pkg holds:
  - cmd, mem-cmd, mem-width and resp enums;
  - exception-code constants;
  - a NB function of cmd and parameters.
- One sub-module: rlwe_vlsu_agu, the beat address generator. It holds base, stride and beat index, and outputs the beat address plus a last-beat flag.

Test Plan:
- LV, LANES=16, BEAT_LANES=4, addr 0x100, zero-wait DMEM -> 4 beats at 0x100/0x110/0x120/0x130, width BEAT; rdy at cycle 9, l_data equals memory image.
- SVS, addr 0x200, stride -8, ack delayed 2 cycles per beat -> 16 WORD beats from 0x200 down to 0x188; wdata lane0 = s_data lane k; single rdy, exc=0.
- LV addr 0x104 -> same-cycle rdy=1, exc=1, code 4, no dmem_req; SVS stride 6 -> code 6.
- LV with ER on beat 2 -> beats 3+ not issued; rdy with exc=1, code 5; lanes 0-7 updated, lanes 8-15 unchanged.
- Reset asserted in WAIT of beat 1, then OK response arrives -> IDLE, outputs 0, response ignored; next LV completes normally.
- LVS addr 0xFFFFFFF8 stride 8 -> addresses wrap to 0x0, 0x8, ...; completes without exception.

Source files
------------

// File: rtl/rlwe_vlsu_pkg.sv
// Shared types and helpers for the RLWE multi-beat vector load/store unit.
// Command, DMEM and exception encodings live here so the LSU and its bench agree.
package rlwe_vlsu_pkg;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_LV   = 3'd1,
    CMD_SV   = 3'd2,
    CMD_LVS  = 3'd3,
    CMD_SVS  = 3'd4
  } cmd_e;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_cmd_e;

  typedef enum logic [1:0] {
    MW_BYTE  = 2'd0,
    MW_HWORD = 2'd1,
    MW_WORD  = 2'd2,
    MW_BEAT  = 2'd3
  } mem_width_e;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ER   = 2'd2,
    RESP_RSVD = 2'd3
  } resp_e;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_ACCESS   = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_ACCESS   = 4'd7;

  function automatic logic is_load(cmd_e c);
    return (c == CMD_LV) || (c == CMD_LVS);
  endfunction

  function automatic logic is_store(cmd_e c);
    return (c == CMD_SV) || (c == CMD_SVS);
  endfunction

  function automatic logic is_strided(cmd_e c);
    return (c == CMD_LVS) || (c == CMD_SVS);
  endfunction

  // Strided commands move one element per beat; unit-stride moves a full beat.
  function automatic int unsigned beat_count(cmd_e c, int unsigned lanes, int unsigned beat_lanes);
    return is_strided(c) ? lanes : lanes / beat_lanes;
  endfunction

endpackage

// File: rtl/rlwe_vlsu_agu.sv
// Beat address generator: keeps a running beat address, the step between
// beats and the beat index, and flags the final beat of the command.
module rlwe_vlsu_agu
  import rlwe_vlsu_pkg::*;
#(
  parameter int AW         = 32,
  parameter int IW         = 5,
  parameter int BEAT_BYTES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          strided_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] stride_i,
  input  logic [IW-1:0] nb_i,
  input  logic          advance_i,
  output logic [AW-1:0] addr_o,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] step_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] nb_q;

  // Accumulating the step avoids a k*stride multiplier; wrap is modulo 2^AW.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (!rst_n) begin
      addr_q <= '0;
      step_q <= '0;
      idx_q  <= '0;
      nb_q   <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
      step_q <= strided_i ? stride_i : AW'(BEAT_BYTES);
      idx_q  <= '0;
      nb_q   <= nb_i;
    end else if (advance_i) begin
      addr_q <= addr_q + step_q;
      idx_q  <= idx_q + IW'(1);
    end
  end

  assign addr_o = addr_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == nb_q - IW'(1));

endmodule

// File: rtl/rlwe_vec_lsu.sv
// Multi-beat vector LSU: splits one EXU vector command into DMEM beats,
// gathers load beats into a vector buffer and returns one completion.
module rlwe_vec_lsu
  import rlwe_vlsu_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int ELEM_W     = 32,
  parameter int BEAT_LANES = 4,
  parameter int AW         = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         exu2lsu_req,
  input  logic [2:0]                   exu2lsu_cmd,
  input  logic [AW-1:0]                exu2lsu_addr,
  input  logic [AW-1:0]                exu2lsu_stride,
  input  logic [LANES*ELEM_W-1:0]      exu2lsu_s_data,
  output logic                         lsu2exu_rdy,
  output logic [LANES*ELEM_W-1:0]      lsu2exu_l_data,
  output logic                         lsu2exu_exc,
  output logic [3:0]                   lsu2exu_exc_code,
  output logic                         lsu_busy,
  output logic                         lsu2dmem_req,
  output logic                         lsu2dmem_cmd,
  output logic [1:0]                   lsu2dmem_width,
  output logic [AW-1:0]                lsu2dmem_addr,
  output logic [BEAT_LANES*ELEM_W-1:0] lsu2dmem_wdata,
  input  logic                         dmem2lsu_req_ack,
  input  logic [BEAT_LANES*ELEM_W-1:0] dmem2lsu_rdata,
  input  logic [1:0]                   dmem2lsu_resp
);

  localparam int VW         = LANES * ELEM_W;
  localparam int BEAT_W     = BEAT_LANES * ELEM_W;
  localparam int BEAT_BYTES = BEAT_LANES * (ELEM_W / 8);
  localparam int OFS_W      = $clog2(BEAT_BYTES);
  localparam int IW         = $clog2(LANES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e        state_q;
  cmd_e          cmd_q;
  logic          err_q;
  logic [VW-1:0] sdata_q;
  logic [VW-1:0] buf_q;

  cmd_e          req_cmd;
  resp_e         resp;
  logic          req_mem;
  logic          req_misalign;
  logic          accept;
  logic          beat_ok;
  logic          beat_er;
  logic [AW-1:0] agu_addr;
  logic [IW-1:0] agu_idx;
  logic          agu_last;

  assign req_cmd      = cmd_e'(exu2lsu_cmd);
  assign resp         = resp_e'(dmem2lsu_resp);
  assign req_mem      = is_load(req_cmd) | is_store(req_cmd);
  assign req_misalign = is_strided(req_cmd) ? |{exu2lsu_addr[1:0], exu2lsu_stride[1:0]}
                                            : |exu2lsu_addr[OFS_W-1:0];
  assign accept       = (state_q == ST_IDLE) && exu2lsu_req && req_mem && !req_misalign;
  assign beat_ok      = (state_q == ST_WAIT) && (resp == RESP_OK);
  assign beat_er      = (state_q == ST_WAIT) && (resp == RESP_ER);

  rlwe_vlsu_agu #(
    .AW         (AW),
    .IW         (IW),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_agu (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .strided_i (is_strided(req_cmd)),
    .base_i    (exu2lsu_addr),
    .stride_i  (exu2lsu_stride),
    .nb_i      (IW'(beat_count(req_cmd, LANES, BEAT_LANES))),
    .advance_i (beat_ok && !agu_last),
    .addr_o    (agu_addr),
    .idx_o     (agu_idx),
    .last_o    (agu_last)
  );

  // NOTE: the store payload is only read after it is captured, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) sdata_q <= exu2lsu_s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      err_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_q   <= req_cmd;
            err_q   <= 1'b0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem2lsu_req_ack) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (beat_ok) begin
            if (is_load(cmd_q)) begin
              if (is_strided(cmd_q)) buf_q[agu_idx*ELEM_W +: ELEM_W] <= dmem2lsu_rdata[ELEM_W-1:0];
              else                   buf_q[agu_idx*BEAT_W +: BEAT_W] <= dmem2lsu_rdata;
            end
            state_q <= agu_last ? ST_DONE : ST_REQ;
          end else if (beat_er) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    lsu2exu_rdy      = 1'b0;
    lsu2exu_exc      = 1'b0;
    lsu2exu_exc_code = '0;
    lsu2dmem_req     = 1'b0;
    lsu2dmem_cmd     = MEM_RD;
    lsu2dmem_width   = MW_BYTE;
    lsu2dmem_addr    = '0;
    lsu2dmem_wdata   = '0;
    case (state_q)
      ST_IDLE: begin
        // Rejections and NONE complete in the request cycle without touching DMEM.
        if (exu2lsu_req && !accept) begin
          lsu2exu_rdy = 1'b1;
          if (req_mem && req_misalign) begin
            lsu2exu_exc      = 1'b1;
            lsu2exu_exc_code = is_load(req_cmd) ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
          end
        end
      end
      ST_REQ: begin
        lsu2dmem_req  = 1'b1;
        lsu2dmem_cmd  = is_store(cmd_q) ? MEM_WR : MEM_RD;
        lsu2dmem_addr = agu_addr;
        if (is_strided(cmd_q)) begin
          lsu2dmem_width = MW_WORD;
          lsu2dmem_wdata = BEAT_W'(sdata_q[agu_idx*ELEM_W +: ELEM_W]);
        end else begin
          lsu2dmem_width = MW_BEAT;
          lsu2dmem_wdata = sdata_q[agu_idx*BEAT_W +: BEAT_W];
        end
      end
      ST_DONE: begin
        lsu2exu_rdy = 1'b1;
        lsu2exu_exc = err_q;
        if (err_q) lsu2exu_exc_code = is_load(cmd_q) ? EXC_LD_ACCESS : EXC_ST_ACCESS;
      end
      default: ;
    endcase
  end

  assign lsu_busy       = (state_q != ST_IDLE);
  assign lsu2exu_l_data = buf_q;

endmodule
